act_requant_stage: RTL and testbench
====================================

Name: act_requant_stage

Overview:
- Streaming requantizer directly upstream of the activation units (relu_sign, leakyRelu_sign, hardtanh_sign, sigmoid_sign).
- Takes wide signed MAC accumulations, adds a per-channel bias, rescales by a fixed arithmetic right shift with rounding, and saturates to WIDTH-bit fixed point.
- Presents data plus a qualifying strobe that drives the activation unit's `data`/`enable` inputs.
- Two-stage pipeline with valid/ready backpressure.

Parameters:
- ACC_WIDTH, 20, signed accumulator and bias width.
- WIDTH, 8, signed output width; matches the downstream activation WIDTH.
- FRAC_SHIFT, 4, right-shift amount from accumulator scale to output scale; legal range 0..ACC_WIDTH-1.

Ports:
- iClk  in  1  clock; all state updates on the rising edge.
- iRst  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear; drops all in-flight beats.
- acc_data  in  ACC_WIDTH  signed accumulator value.
- bias  in  ACC_WIDTH  signed bias; sampled together with acc_data.
- acc_valid  in  1  input beat valid.
- acc_ready  out  1  stage can accept an input beat.
- data_out  out  WIDTH  signed requantized value; connects to the activation `data` input.
- data_en  out  1  output beat valid; connects to the activation `enable` input.
- out_ready  in  1  downstream consumes the beat this cycle.

Behaviour:
- Reset (iRst=0, asynchronous): s1_valid=0, data_en=0, data_out=0, all pipeline registers cleared. acc_ready=1 immediately after reset is released.
- Handshake:
  - An input transfer occurs when acc_valid && acc_ready.
  - An output transfer occurs when data_en && out_ready.
  - data_out and data_en hold stable while data_en=1 && out_ready=0.
- Stage readiness:
  - s2_ready = !data_en || out_ready.
  - s1_ready = !s1_valid || s2_ready.
  - acc_ready = s1_ready. This is combinational from out_ready and is permitted.
- Stage 1, when s1_ready:
  - sum <= acc_data + bias, computed at ACC_WIDTH+1 bits so it cannot overflow.
  - s1_valid <= acc_valid.
- Stage 2, when s2_ready:
  - Take rnd = sum + (FRAC_SHIFT>0 ? 1<<(FRAC_SHIFT-1) : 0), computed at ACC_WIDTH+2 bits.
  - Take q = rnd >>> FRAC_SHIFT. Rounding is half toward +infinity.
  - Saturate: if q > 2^(WIDTH-1)-1, data_out <= 2^(WIDTH-1)-1; if q < -2^(WIDTH-1), data_out <= -2^(WIDTH-1); otherwise data_out <= q[WIDTH-1:0].
  - data_en <= s1_valid.
- Latency: an input accepted in cycle N appears with data_en=1 in cycle N+2 when unstalled.
- Throughput: 1 beat per cycle sustained while out_ready=1.
- Capacity: 2 beats (stage 1 + output register). With out_ready=0 and both stages full, acc_ready=0.
- Simultaneous events:
  - A full pipeline with out_ready=1 accepts a new input in the same cycle the output retires; no bubble is inserted.
- Flush:
  - Next edge: s1_valid=0, data_en=0, data_out=0.
  - acc_ready is forced to 0 during the flush cycle, so no input is accepted that cycle.
  - Flush has priority over all advances.
- Reset mid-operation: all in-flight beats are lost with no partial output. data_en falls asynchronously with iRst.
- No data_en=1 beat is produced from an unaccepted input. data_out must be 0 whenever data_en=0 after reset or flush, because the downstream unit treats enable=0 as zero output.

Optional Feature:
- Macro: REQUANT_SATCNT_EN.
- When defined:
  - Adds output port sat_count, 16 bits: count of output beats clamped (positive or negative) since the last reset or flush.
  - Incremented when a saturated value is loaded into the output register. Saturates at 16'hFFFF with no wrap.
  - Cleared by iRst and flush.
- When undefined:
  - The port and counter are absent; all other behaviour is identical.

Test Plan (WIDTH=8, ACC_WIDTH=20, FRAC_SHIFT=4, out_ready=1 unless noted):
- Basic: acc=256, bias=0 -> data_out=0x10 with data_en=1 exactly 2 cycles after acceptance. acc=1000, bias=8 -> (1008+8)>>>4=63 -> 0x3F.
- Saturation: acc=5000 -> 0x7F; acc=-5000 -> 0x80. With REQUANT_SATCNT_EN, sat_count=2 afterwards.
- Rounding, negative side: acc=-24 -> 0xFF; acc=-25 -> 0xFE; acc=-8 -> 0x00; acc=7, bias=0 -> 0x00; acc=8 -> 0x01.
- Backpressure: out_ready=0, acc_valid=1 streaming values 1,2,3 (times 16):
  - Exactly 2 beats are accepted, then acc_ready=0.
  - data_out holds 0x01 stable.
  - Release out_ready -> outputs 0x01, 0x02, 0x03 in order, no loss or duplication.
- Back-to-back: 8 consecutive beats with acc=16*k -> outputs k=0..7 on 8 consecutive cycles, acc_ready never drops.
- Flush/reset: assert flush with 2 beats in flight -> next cycle data_en=0, data_out=0, nothing emitted later. Repeat using iRst=0 asserted asynchronously between edges -> data_en falls immediately.

Source files
------------

// File: rtl/act_requant_stage_if.sv
// Stream bundle between the MAC accumulator side and the activation unit side
// of the requantizer.
interface act_requant_stage_if #(
  parameter int ACC_WIDTH = 20,
  parameter int WIDTH     = 8
);
  logic signed [ACC_WIDTH-1:0] acc_data;
  logic signed [ACC_WIDTH-1:0] bias;
  logic                        acc_valid;
  logic                        acc_ready;
  logic signed [WIDTH-1:0]     data_out;
  logic                        data_en;
  logic                        out_ready;

  // Handshake: a beat moves on a side exactly in a cycle where its valid
  // (acc_valid / data_en) and ready (acc_ready / out_ready) are both high.
  modport slave (
    input  acc_data, bias, acc_valid, out_ready,
    output acc_ready, data_out, data_en
  );

  modport master (
    output acc_data, bias, acc_valid, out_ready,
    input  acc_ready, data_out, data_en
  );
endinterface

// File: rtl/act_requant_stage.sv
// Two-stage requantizer: bias add, rounded arithmetic right shift, saturation.
// Optional clamp counter port sat_count enabled by macro REQUANT_SATCNT_EN.
module act_requant_stage #(
  parameter int ACC_WIDTH  = 20,
  parameter int WIDTH      = 8,
  parameter int FRAC_SHIFT = 4
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 flush,
  act_requant_stage_if.slave   bus
`ifdef REQUANT_SATCNT_EN
  ,
  output logic [15:0]          sat_count
`endif
);

  localparam int SW = ACC_WIDTH + 1;
  localparam int RW = ACC_WIDTH + 2;

  localparam logic signed [RW-1:0] RND =
    (FRAC_SHIFT > 0) ? (RW'(1) << ((FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0)) : '0;
  localparam logic signed [RW-1:0] MAXV = {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX_OUT = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_OUT = {1'b1, {(WIDTH-1){1'b0}}};

  logic                    s1_valid_q, s1_valid_d;
  logic signed [SW-1:0]    sum_q, sum_d;
  logic signed [WIDTH-1:0] data_out_q, data_out_d;
  logic                    data_en_q, data_en_d;

  logic                    s1_ready;
  logic                    s2_ready;
  logic signed [RW-1:0]    rnd;
  logic signed [RW-1:0]    q;
  logic                    sat_hi;
  logic                    sat_lo;
  logic signed [WIDTH-1:0] sat_val;

  always_comb begin
    s2_ready = !data_en_q || bus.out_ready;
    s1_ready = !s1_valid_q || s2_ready;

    rnd     = {sum_q[SW-1], sum_q} + RND;
    q       = rnd >>> FRAC_SHIFT;
    sat_hi  = (q > MAXV);
    sat_lo  = (q < MINV);
    sat_val = sat_hi ? MAX_OUT : (sat_lo ? MIN_OUT : q[WIDTH-1:0]);

    s1_valid_d = s1_valid_q;
    sum_d      = sum_q;
    data_en_d  = data_en_q;
    data_out_d = data_out_q;

    if (flush) begin
      s1_valid_d = 1'b0;
      sum_d      = '0;
      data_en_d  = 1'b0;
      data_out_d = '0;
    end else begin
      if (s1_ready) begin
        s1_valid_d = bus.acc_valid;
        sum_d      = bus.acc_valid ? ({bus.acc_data[ACC_WIDTH-1], bus.acc_data} +
                                      {bus.bias[ACC_WIDTH-1], bus.bias}) : '0;
      end
      // Bubbles load zero so the activation unit never sees stale data.
      if (s2_ready) begin
        data_en_d  = s1_valid_q;
        data_out_d = s1_valid_q ? sat_val : '0;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      s1_valid_q <= 1'b0;
      sum_q      <= '0;
      data_en_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      sum_q      <= sum_d;
      data_en_q  <= data_en_d;
      data_out_q <= data_out_d;
    end
  end

  assign bus.acc_ready = s1_ready && !flush;
  assign bus.data_en   = data_en_q;
  assign bus.data_out  = data_out_q;

`ifdef REQUANT_SATCNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (flush) begin
      sat_cnt_d = '0;
    end else if (s2_ready && s1_valid_q && (sat_hi || sat_lo) && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_act_requant_stage.sv
// Bench for act_requant_stage: directed literal cases plus a randomized stream
// compared against an arithmetic model of the requantization rules.
module tb_act_requant_stage;
  localparam int ACC_W = 20;
  localparam int W     = 8;
  localparam int FS    = 4;

  logic iClk  = 1'b0;
  logic iRst  = 1'b0;
  logic flush = 1'b0;

  always #5 iClk = ~iClk;

  act_requant_stage_if #(.ACC_WIDTH(ACC_W), .WIDTH(W)) bus ();

`ifdef REQUANT_SATCNT_EN
  logic [15:0] sat_count;
`endif

  act_requant_stage #(.ACC_WIDTH(ACC_W), .WIDTH(W), .FRAC_SHIFT(FS)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .flush     (flush),
    .bus       (bus)
`ifdef REQUANT_SATCNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Round half up, shift, clamp: straight from the arithmetic definition.
  function automatic logic [W-1:0] model(input longint a, input longint b);
    longint s;
    longint qq;
    logic [63:0] r;
    s  = a + b;
    qq = (s + ((longint'(1) << FS) >> 1)) >>> FS;
    if (qq > longint'(2**(W-1) - 1)) qq = longint'(2**(W-1) - 1);
    if (qq < -longint'(2**(W-1)))    qq = -longint'(2**(W-1));
    r = qq;
    return r[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Compare process: samples 2ns before every rising edge.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_dout  = '0;

  initial begin
    forever begin
      @(negedge iClk);
      #3;
      if (!iRst) begin
        exp_q.delete();
        chk("reset_data_en", {31'd0, bus.data_en}, 32'd0);
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_hold_en", {31'd0, bus.data_en}, 32'd1);
          chk("stall_hold_data", {24'd0, bus.data_out}, {24'd0, prev_dout});
        end
        if (bus.data_en) begin
          if (bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_beat actual=%0h required=none", bus.data_out);
            end else begin
              logic [W-1:0] e;
              e = exp_q.pop_front();
              if (bus.data_out !== e) begin
                errors++;
                $display("FAIL stream_data actual=%0h required=%0h", bus.data_out, e);
              end
            end
          end
        end else begin
          chk("idle_data_zero", {24'd0, bus.data_out}, 32'd0);
        end
        prev_stall = bus.data_en && !bus.out_ready && !flush;
        prev_dout  = bus.data_out;
        if (flush) begin
          chk("flush_ready_low", {31'd0, bus.acc_ready}, 32'd0);
          exp_q.delete();
        end else if (bus.acc_valid && bus.acc_ready) begin
          exp_q.push_back(model(longint'(bus.acc_data), longint'(bus.bias)));
        end
      end
    end
  end

  task automatic send_and_check(input int a, input int b, input logic [W-1:0] e, input string nm);
    @(negedge iClk);
    bus.acc_data  = ACC_W'(a);
    bus.bias      = ACC_W'(b);
    bus.acc_valid = 1'b1;
    bus.out_ready = 1'b1;
    #3 chk({nm, "_ready"}, {31'd0, bus.acc_ready}, 32'd1);
    @(negedge iClk);
    bus.acc_valid = 1'b0;
    #3 chk({nm, "_lat1"}, {31'd0, bus.data_en}, 32'd0);
    @(negedge iClk);
    #3 chk({nm, "_en"}, {31'd0, bus.data_en}, 32'd1);
    chk({nm, "_data"}, {24'd0, bus.data_out}, {24'd0, e});
  endtask

  task automatic fill_two(input int base);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge iClk);
      bus.acc_data  = ACC_W'(16 * (base + i));
      bus.bias      = '0;
      bus.acc_valid = 1'b1;
    end
    @(negedge iClk);
    bus.acc_valid = 1'b0;
  endtask

  int idx;
  logic pending;

  initial begin
    bus.acc_data  = '0;
    bus.bias      = '0;
    bus.acc_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge iClk);
    iRst = 1'b1;
    #3;
    chk("rst_acc_ready", {31'd0, bus.acc_ready}, 32'd1);
    chk("rst_data_en", {31'd0, bus.data_en}, 32'd0);
    chk("rst_data_out", {24'd0, bus.data_out}, 32'd0);

    send_and_check(256, 0, 8'h10, "basic_256");
    send_and_check(1000, 8, 8'h3F, "basic_1000");
    send_and_check(5000, 0, 8'h7F, "sat_pos");
    send_and_check(-5000, 0, 8'h80, "sat_neg");
`ifdef REQUANT_SATCNT_EN
    chk("sat_count_two", {16'd0, sat_count}, 32'd2);
`endif
    send_and_check(-24, 0, 8'hFF, "rnd_m24");
    send_and_check(-25, 0, 8'hFE, "rnd_m25");
    send_and_check(-8, 0, 8'h00, "rnd_m8");
    send_and_check(7, 0, 8'h00, "rnd_7");
    send_and_check(8, 0, 8'h01, "rnd_8");

    // Backpressure: two beats fit, the third waits.
    @(negedge iClk);
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge iClk);
      bus.acc_data  = ACC_W'(16 * (idx + 1));
      bus.bias      = '0;
      bus.acc_valid = 1'b1;
      #3;
      if (c >= 3) chk("bp_hold_01", {24'd0, bus.data_out}, 32'h01);
      if (bus.acc_ready) idx++;
    end
    chk("bp_accepted", idx, 32'd2);
    chk("bp_ready_low", {31'd0, bus.acc_ready}, 32'd0);
    @(negedge iClk);
    bus.out_ready = 1'b1;
    #3;
    chk("bp_release_ready", {31'd0, bus.acc_ready}, 32'd1);
    chk("bp_out_1", {24'd0, bus.data_out}, 32'h01);
    @(negedge iClk);
    bus.acc_valid = 1'b0;
    #3 chk("bp_out_2", {24'd0, bus.data_out}, 32'h02);
    @(negedge iClk);
    #3 chk("bp_out_3", {24'd0, bus.data_out}, 32'h03);
    repeat (3) @(negedge iClk);

    // Back-to-back stream, one beat per cycle.
    for (int k = 0; k < 10; k++) begin
      @(negedge iClk);
      bus.acc_valid = (k < 8);
      bus.acc_data  = ACC_W'(16 * k);
      bus.bias      = '0;
      #3;
      if (k < 8) chk("b2b_ready", {31'd0, bus.acc_ready}, 32'd1);
      if (k >= 2) begin
        chk("b2b_en", {31'd0, bus.data_en}, 32'd1);
        chk("b2b_data", {24'd0, bus.data_out}, k - 2);
      end
    end
    repeat (2) @(negedge iClk);

    // Flush with two beats in flight.
    fill_two(9);
    chk("flush_pre_en", {31'd0, bus.data_en}, 32'd1);
    @(negedge iClk);
    flush = 1'b1;
    bus.acc_valid = 1'b1;
    #3 chk("flush_acc_ready", {31'd0, bus.acc_ready}, 32'd0);
    @(negedge iClk);
    flush = 1'b0;
    bus.acc_valid = 1'b0;
    bus.out_ready = 1'b1;
    #3;
    chk("flush_data_en", {31'd0, bus.data_en}, 32'd0);
    chk("flush_data_out", {24'd0, bus.data_out}, 32'd0);
`ifdef REQUANT_SATCNT_EN
    chk("flush_sat_count", {16'd0, sat_count}, 32'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      #3 chk("flush_quiet", {31'd0, bus.data_en}, 32'd0);
    end

    // Asynchronous reset between edges.
    fill_two(20);
    chk("arst_pre_en", {31'd0, bus.data_en}, 32'd1);
    @(posedge iClk);
    #2 iRst = 1'b0;
    #1;
    chk("arst_data_en", {31'd0, bus.data_en}, 32'd0);
    chk("arst_data_out", {24'd0, bus.data_out}, 32'd0);
    @(negedge iClk);
    @(negedge iClk);
    iRst = 1'b1;
    bus.out_ready = 1'b1;
    #3;
    chk("arst_acc_ready", {31'd0, bus.acc_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      #3 chk("arst_quiet", {31'd0, bus.data_en}, 32'd0);
    end

    // Randomized traffic; a presented beat is held until it is taken.
    pending = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge iClk);
      flush         = ($urandom_range(0, 59) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!pending) begin
        bus.acc_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 0) begin
          bus.acc_data = ACC_W'(int'($urandom_range(0, 6000)) - 3000);
          bus.bias     = ACC_W'(int'($urandom_range(0, 400)) - 200);
        end else begin
          bus.acc_data = ACC_W'($urandom);
          bus.bias     = ACC_W'($urandom);
        end
      end
      #3;
      pending = bus.acc_valid && !bus.acc_ready;
    end

    @(negedge iClk);
    flush = 1'b0;
    bus.acc_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(negedge iClk);
    #3 chk("drain_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
